// File: rtl/timer_pkg.sv
// Shared types and constants for the memory-mapped countdown timer that feeds one HWInt line.
package timer_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_e;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PRESET = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;

   localparam int unsigned CTRL_EN      = 0;
   localparam int unsigned CTRL_MODE_LO = 1;
   localparam int unsigned CTRL_MODE_HI = 2;
   localparam int unsigned CTRL_IM      = 3;

   localparam logic [1:0] MODE_ONESHOT = 2'd0;
   localparam logic [1:0] MODE_RELOAD  = 2'd1;

endpackage

// File: rtl/timer_irq_src.sv
// Programmable countdown timer with CTRL/PRESET/COUNT registers; raises a level (one-shot)
// or a single-cycle periodic pulse (auto-reload) interrupt request.
module timer_irq_src
   import timer_pkg::*;
#(
   parameter int unsigned COUNT_W = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        irq
);

   logic [3:0]         ctrl_q, ctrl_d;
   logic [COUNT_W-1:0] preset_q, preset_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               pending_q, pending_d;
   state_e             state_q, state_d;

   logic               ctrl_wr, preset_wr;
   logic [1:0]         mode;

   assign ctrl_wr   = we && (addr == ADDR_CTRL);
   assign preset_wr = we && (addr == ADDR_PRESET);
   assign mode      = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO];

   always_comb begin
      ctrl_d    = ctrl_q;
      preset_d  = preset_q;
      count_d   = count_q;
      pending_d = pending_q;
      state_d   = state_q;

      // A bus write pre-empts the FSM and restarts it from IDLE.
      if (ctrl_wr || preset_wr) begin
         if (ctrl_wr) begin
            ctrl_d = din[3:0];
         end
         if (preset_wr) begin
            preset_d = din[COUNT_W-1:0];
         end
         pending_d = 1'b0;
         state_d   = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               // Auto-reload pulse lasts only the cycle spent in IDLE after INT.
               if (mode == MODE_RELOAD) begin
                  pending_d = 1'b0;
               end
               if (ctrl_q[CTRL_EN]) begin
                  state_d = LOAD;
               end
            end
            LOAD: begin
               count_d = preset_q;
               state_d = CNT;
            end
            CNT: begin
               if (count_q > COUNT_W'(1)) begin
                  count_d = count_q - COUNT_W'(1);
               end else begin
                  count_d = '0;
                  state_d = INT;
               end
            end
            INT: begin
               pending_d = 1'b1;
               if (mode != MODE_RELOAD) begin
                  ctrl_d[CTRL_EN] = 1'b0;
               end
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl_q    <= '0;
         preset_q  <= '0;
         count_q   <= '0;
         pending_q <= 1'b0;
         state_q   <= IDLE;
      end else begin
         ctrl_q    <= ctrl_d;
         preset_q  <= preset_d;
         count_q   <= count_d;
         pending_q <= pending_d;
         state_q   <= state_d;
      end
   end

   always_comb begin
      dout = 32'd0;
      unique case (addr)
         ADDR_CTRL:   dout = {28'd0, ctrl_q};
         ADDR_PRESET: dout = 32'(preset_q);
         ADDR_COUNT:  dout = 32'(count_q);
         default:     dout = 32'd0;
      endcase
   end

   assign irq = pending_q & ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_timer_irq_src.sv
// Self-checking bench for timer_irq_src: directed scenarios plus a randomized run against a
// phase-counting reference model.
module tb_timer_irq_src;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  addr;
   logic        we;
   logic [31:0] din;
   wire  [31:0] dout;
   wire         irq;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   timer_irq_src #(.COUNT_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .din   (din),
      .dout  (dout),
      .irq   (irq)
   );

   // Reference model: k counts edges since the timer last (re)started from idle.
   logic [3:0]  m_ctrl;
   logic [31:0] m_preset;
   logic [31:0] m_count;
   bit          m_pend;
   int          m_k;

   function automatic void m_reset();
      m_ctrl = '0; m_preset = '0; m_count = '0; m_pend = 1'b0; m_k = 0;
   endfunction

   function automatic void m_edge(input bit w, input logic [1:0] a, input logic [31:0] d);
      int pe;
      if (w && (a == 2'd0 || a == 2'd1)) begin
         if (a == 2'd0) m_ctrl = d[3:0];
         else           m_preset = d;
         m_pend = 1'b0;
         m_k    = 0;
      end else if (m_ctrl[0] || m_k > 0) begin
         m_k++;
         pe = (m_preset == 0) ? 1 : int'(m_preset);
         if (m_k == 1) begin
            if (m_ctrl[2:1] == 2'd1) m_pend = 1'b0;
         end else if (m_k <= pe + 1) begin
            m_count = m_preset - 32'(m_k - 2);
         end else if (m_k == pe + 2) begin
            m_count = 0;
         end else if (m_k == pe + 3) begin
            m_pend = 1'b1;
            m_k    = 0;
            if (m_ctrl[2:1] != 2'd1) m_ctrl[0] = 1'b0;
         end
      end
   endfunction

   function automatic logic [31:0] exp_dout(input logic [1:0] a);
      case (a)
         2'd0:    return {28'd0, m_ctrl};
         2'd1:    return m_preset;
         2'd2:    return m_count;
         default: return 32'd0;
      endcase
   endfunction

   function automatic bit exp_irq();
      return m_pend & m_ctrl[3];
   endfunction

   task automatic tick(input bit w, input logic [1:0] a, input logic [31:0] d);
      we = w; addr = a; din = d;
      @(posedge clk);
      m_edge(w, a, d);
      #1;
      we = 1'b0;
   endtask

   task automatic test_reset();
      we = 1'b0; addr = 2'd0; din = '0;
      reset = 1'b0;
      m_reset();
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         checks++;
         if (irq !== 1'b0) begin
            errors++; $display("FAIL reset_irq_held cyc=%0d got %b want 0", i, irq);
         end
      end
      reset = 1'b1;
      @(posedge clk); #1;
      for (int a = 0; a < 4; a++) begin
         addr = 2'(a); #1;
         checks++;
         if (dout !== 32'd0) begin
            errors++; $display("FAIL reset_dout addr=%0d got %h want 0", a, dout);
         end
      end
      checks++;
      if (irq !== 1'b0) begin
         errors++; $display("FAIL reset_irq got %b want 0", irq);
      end
   endtask

   task automatic test_oneshot();
      int rise = -1;
      tick(1'b1, 2'd1, 32'd5);
      tick(1'b1, 2'd0, 32'h9);
      for (int i = 1; i <= 12; i++) begin
         tick(1'b0, 2'd2, 32'd0);
         checks++;
         if (dout !== exp_dout(2'd2)) begin
            errors++; $display("FAIL oneshot_count t=%0d got %0d want %0d", i, dout, exp_dout(2'd2));
         end
         checks++;
         if (irq !== exp_irq()) begin
            errors++; $display("FAIL oneshot_irq t=%0d got %b want %b", i, irq, exp_irq());
         end
         if (irq === 1'b1 && rise < 0) rise = i;
      end
      checks++;
      if (rise != 8) begin
         errors++; $display("FAIL oneshot_latency got %0d want 8", rise);
      end
      addr = 2'd0; #1;
      checks++;
      if (dout !== 32'h8) begin
         errors++; $display("FAIL oneshot_ctrl_en_cleared got %h want 8", dout);
      end
      tick(1'b1, 2'd0, 32'h8);
      checks++;
      if (irq !== 1'b0) begin
         errors++; $display("FAIL oneshot_clear_on_ctrl got %b want 0", irq);
      end
   endtask

   task automatic test_reload();
      int pulses = 0;
      tick(1'b1, 2'd1, 32'd2);
      tick(1'b1, 2'd0, 32'hB);
      for (int i = 1; i <= 16; i++) begin
         tick(1'b0, 2'd2, 32'd0);
         checks++;
         if (irq !== ((i % 5) == 0)) begin
            errors++; $display("FAIL reload_pulse t=%0d got %b want %b", i, irq, (i % 5) == 0);
         end
         checks++;
         if (dout !== exp_dout(2'd2)) begin
            errors++; $display("FAIL reload_count t=%0d got %0d want %0d", i, dout, exp_dout(2'd2));
         end
         if (irq === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 3) begin
         errors++; $display("FAIL reload_pulse_count got %0d want 3", pulses);
      end
   endtask

   task automatic test_masked_and_zero();
      tick(1'b1, 2'd1, 32'd3);
      tick(1'b1, 2'd0, 32'h1);
      for (int i = 1; i <= 10; i++) begin
         tick(1'b0, 2'd0, 32'd0);
         checks++;
         if (irq !== 1'b0) begin
            errors++; $display("FAIL masked_irq t=%0d got %b want 0", i, irq);
         end
      end
      checks++;
      if (dout !== 32'h0) begin
         errors++; $display("FAIL masked_en_cleared got %h want 0", dout);
      end
      tick(1'b1, 2'd1, 32'd0);
      tick(1'b1, 2'd0, 32'h9);
      for (int i = 1; i <= 6; i++) begin
         tick(1'b0, 2'd2, 32'd0);
         checks++;
         if (irq !== (i >= 4)) begin
            errors++; $display("FAIL preset0_irq t=%0d got %b want %b", i, irq, i >= 4);
         end
      end
   endtask

   task automatic test_midcount();
      bit found = 1'b0;
      tick(1'b1, 2'd1, 32'd10);
      tick(1'b1, 2'd0, 32'h9);
      for (int i = 0; i < 20 && !found; i++) begin
         tick(1'b0, 2'd2, 32'd0);
         if (dout === 32'd6) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL midcount_reach6 got %0d want 6", dout);
      end
      tick(1'b1, 2'd1, 32'd2);
      for (int i = 1; i <= 7; i++) begin
         if (i == 1) tick(1'b1, 2'd2, 32'hFFFF);
         else        tick(1'b0, 2'd2, 32'd0);
         checks++;
         if (dout !== exp_dout(2'd2)) begin
            errors++; $display("FAIL midcount_count t=%0d got %0d want %0d", i, dout, exp_dout(2'd2));
         end
         checks++;
         if (irq !== (i >= 5)) begin
            errors++; $display("FAIL midcount_irq t=%0d got %b want %b", i, irq, i >= 5);
         end
      end
   endtask

   task automatic test_async_reset();
      bit seen = 1'b0;
      tick(1'b1, 2'd1, 32'd1);
      tick(1'b1, 2'd0, 32'h9);
      for (int i = 0; i < 10 && !seen; i++) begin
         tick(1'b0, 2'd0, 32'd0);
         if (irq === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++; $display("FAIL async_irq_before_reset got %b want 1", irq);
      end
      #1 reset = 1'b0;
      m_reset();
      #1;
      checks++;
      if (irq !== 1'b0) begin
         errors++; $display("FAIL async_irq_drop got %b want 0", irq);
      end
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      for (int a = 0; a < 3; a++) begin
         addr = 2'(a); #1;
         checks++;
         if (dout !== 32'd0) begin
            errors++; $display("FAIL async_regs addr=%0d got %h want 0", a, dout);
         end
      end
   endtask

   task automatic test_random();
      bit          w;
      logic [1:0]  a, ra;
      logic [31:0] d;
      for (int i = 0; i < 3000; i++) begin
         w = ($urandom_range(0, 11) == 0);
         a = 2'($urandom_range(0, 3));
         d = (a == 2'd1) ? 32'($urandom_range(0, 9)) : $urandom;
         // Keep IM set most of the time so irq is observable.
         if (a == 2'd0 && $urandom_range(0, 3) != 0) d[3] = 1'b1;
         tick(w, a, d);
         ra = 2'($urandom_range(0, 3));
         addr = ra; #1;
         checks++;
         if (dout !== exp_dout(ra)) begin
            errors++; $display("FAIL random_dout i=%0d addr=%0d got %h want %h", i, ra, dout,
                                exp_dout(ra));
         end
         checks++;
         if (irq !== exp_irq()) begin
            errors++; $display("FAIL random_irq i=%0d got %b want %b", i, irq, exp_irq());
         end
      end
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_reload();
      test_masked_and_zero();
      test_midcount();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/timer_irq_src.md
Name: timer_irq_src

Overview:
- Memory-mapped programmable countdown timer that produces a hardware interrupt request for the coprocessor's HWInt[7:2] inputs.
- Acts as the source end of the interrupt path. One instance drives one HWInt bit.
- The CPU bridge reads and writes three 32-bit registers: CTRL, PRESET and COUNT.
- Supports a one-shot mode (level interrupt, held until software services it) and an auto-reload mode (periodic single-cycle pulse).

Parameters:
- COUNT_W, default 32: width of PRESET and COUNT. Values narrower than 32 are zero-extended on read and truncated on write.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset (reset==0 clears all state immediately)
- addr  in  2  word select: 0=CTRL, 1=PRESET, 2=COUNT, 3=unmapped
- we  in  1  write strobe, sampled on the rising edge of clk
- din  in  32  write data
- dout  out  32  combinational read data for addr
- irq  out  1  interrupt request to CP0 HWInt; equals pending & CTRL.IM

Behaviour:
- CTRL fields:
  - bit0 EN: enable.
  - bits2:1 MODE: 0 = one-shot, 1 = auto-reload, 2/3 behave as 0 but read back as written.
  - bit3 IM: interrupt mask.
  - bits31:4 read as 0 and ignore writes.
- Reset values: CTRL=0, PRESET=0, COUNT=0, pending=0, state=IDLE, irq=0. dout follows addr and reads 0 at every address except 3 (also 0).
- Reads: addr0 returns {28'b0, CTRL[3:0]}; addr1 returns PRESET; addr2 returns COUNT; addr3 returns 0.
- Writes:
  - CTRL and PRESET are writable.
  - COUNT is read-only; writes to it and to addr3 are ignored.
  - A write to CTRL or PRESET on an edge also clears pending and forces state to IDLE on that same edge. The bus write has priority over every FSM update in that cycle.
- FSM (advances only when there is no CTRL/PRESET write that cycle):
  - IDLE: if EN, go to LOAD; otherwise stay. COUNT holds.
  - LOAD: COUNT<=PRESET, then go to CNT.
  - CNT: if COUNT>1, COUNT<=COUNT-1 and stay. Otherwise COUNT<=0 and go to INT. PRESET=0 therefore behaves like PRESET=1.
  - INT in MODE 1: pending<=1, go to IDLE. pending auto-clears on the next edge, giving a 1-cycle pulse. EN stays set, so the timer reloads.
  - INT in any other MODE: pending<=1, EN<=0, go to IDLE. pending is held until software writes CTRL or PRESET.
- Latency: with write edge T0 setting EN (PRESET=P≥1), pending rises at edge T0+P+3.
  - One-shot mode: a single assertion.
  - Auto-reload mode: pulse period is P+3 cycles and pulse width is 1 cycle.
- Masking:
  - IM=0 suppresses irq but not pending. Setting IM later re-exposes a held one-shot pending only if no CTRL write cleared it.
  - Because a CTRL write clears pending, software must set IM together with EN.
- Reset mid-count: all state returns to reset values immediately and asynchronously. irq drops without waiting for clk.
- Counter arithmetic is unsigned modulo 2^COUNT_W. COUNT never decrements below 0 and never wraps.

Decomposition:
- Package timer_pkg holds:
  - the state enum (IDLE, LOAD, CNT, INT)
  - address constants (ADDR_CTRL=0, ADDR_PRESET=1, ADDR_COUNT=2)
  - CTRL bit positions (EN=0, MODE=2:1, IM=3)
  - mode codes (MODE_ONESHOT=0, MODE_RELOAD=1)
- No sub-module. The block is a single FSM plus a register file.

Test Plan:
- Reset low, then high; read all addresses -> dout=0 everywhere, irq=0, and irq=0 while reset is held low with clk running.
- PRESET=5, then CTRL=0x9 (EN, one-shot, IM) at edge T0 -> COUNT reads 5,4,3,2,1,0; irq rises at T0+8 and stays high; CTRL reads 0x8 (EN cleared). A later CTRL write drops irq on that edge.
- PRESET=2, CTRL=0xB (EN, auto-reload, IM) at T0 -> irq pulses 1 cycle at T0+5, T0+10, T0+15; COUNT reloads to 2 between pulses.
- One-shot with PRESET=3 and IM=0 -> irq never asserts while the internal one-shot expiry still occurs (EN clears). Repeat with PRESET=0 -> irq at T0+4, identical to PRESET=1.
- Mid-count: PRESET=10, CTRL=0x9, then write PRESET=2 on the edge where COUNT=6 -> COUNT holds 6 for one cycle (IDLE), LOAD gives 2, and irq fires 5 edges after the PRESET write. A write to addr2 is ignored.
- Assert reset low asynchronously while irq=1 in one-shot mode -> irq falls before the next clk edge; all registers read 0 after release.
